// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI master among four requesters, with timeout and inter-transaction gap
module spi_master_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd4096,
    parameter logic [1:0]  GAP_CYC = 2'd2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [15:0]  req_len,
    input  logic [15:0]  req_period,
    input  logic [3:0]   req_loop,
    input  logic [127:0] req_odata,
    output logic [3:0]   gnt,
    output logic [3:0]   done,
    output logic [3:0]   err,
    output logic [31:0]  rdata,
    output logic         busy,
    output logic         spi_start,
    output logic         spi_loop,
    output logic [3:0]   spi_len,
    output logic [3:0]   spi_period,
    output logic [31:0]  spi_odata,
    input  logic         spi_end,
    input  logic [31:0]  spi_idata
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2;
    // The IDLE arbitration cycle is the last low cycle of the gap, so GAP itself lasts GAP_CYC-1 cycles.
    localparam logic [1:0] GAP_LAST = GAP_CYC - 2'd2;
    logic [1:0]  state, ptr, win, gap_cnt;
    logic [15:0] cnt;
    logic        fin_ok, tmo;
    assign fin_ok = spi_end && cnt != 16'd0;
    assign tmo = cnt == TIMEOUT;
    always_comb begin
        win = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[ptr + 2'(i)]) win = ptr + 2'(i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gap_cnt    <= '0;
            cnt        <= '0;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            spi_start  <= 1'b0;
            spi_loop   <= 1'b0;
            spi_len    <= '0;
            spi_period <= '0;
            spi_odata  <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: if (|req) begin
                    state      <= RUN;
                    ptr        <= win + 2'd1;
                    cnt        <= '0;
                    busy       <= 1'b1;
                    gnt        <= 4'b0001 << win;
                    spi_start  <= 1'b1;
                    spi_len    <= req_len[4*win +: 4];
                    spi_period <= req_period[4*win +: 4];
                    spi_loop   <= req_loop[win];
                    spi_odata  <= req_odata[32*win +: 32];
                end
                RUN: begin
                    cnt <= cnt + 16'd1;
                    if (fin_ok || tmo) begin
                        done      <= fin_ok ? gnt : 4'd0;
                        err       <= fin_ok ? 4'd0 : gnt;
                        rdata     <= fin_ok ? spi_idata : rdata;
                        gnt       <= '0;
                        spi_start <= 1'b0;
                        gap_cnt   <= '0;
                        busy      <= GAP_CYC > 2'd1;
                        state     <= (GAP_CYC > 2'd1) ? GAP : IDLE;
                    end
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 2'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: randomized directed bench; the bench plays the SPI master and predicts arbitration outcomes
module tb_spi_master_arbiter;
    localparam int TO = 20;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   req_loop = '0;
    logic [15:0]  req_len = '0;
    logic [15:0]  req_period = '0;
    logic [127:0] req_odata = '0;
    logic         spi_end = 1'b0;
    logic [31:0]  spi_idata = '0;
    logic [3:0]   gnt, done, err, spi_len, spi_period;
    logic [31:0]  rdata, spi_odata;
    logic         busy, spi_start, spi_loop;
    int           vectors = 0;
    int           miscompares = 0;
    int           mptr = 0;
    logic [31:0]  mrdata = '0;

    spi_master_arbiter #(.TIMEOUT(16'd20), .GAP_CYC(2'd2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .req_period(req_period),
        .req_loop(req_loop), .req_odata(req_odata), .gnt(gnt), .done(done), .err(err),
        .rdata(rdata), .busy(busy), .spi_start(spi_start), .spi_loop(spi_loop),
        .spi_len(spi_len), .spi_period(spi_period), .spi_odata(spi_odata),
        .spi_end(spi_end), .spi_idata(spi_idata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic scramble();
        req_len = 16'($urandom);
        req_period = 16'($urandom);
        req_loop = 4'($urandom);
        req_odata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at a falling edge in IDLE with req already driven; ends on the done/err cycle.
    task automatic txn(input int lat, input bit e0);
        int w, stop;
        bit ok;
        logic [3:0] eg, el, ep;
        logic elp;
        logic [31:0] eo, id;
        w = pick(req, mptr);
        eg = 4'(1 << w);
        el = req_len[4*w +: 4];
        ep = req_period[4*w +: 4];
        elp = req_loop[w];
        eo = req_odata[32*w +: 32];
        ok = lat >= 1 && lat <= TO;
        stop = ok ? lat : TO;
        id = elp ? eo : $urandom;
        @(negedge clk);
        chk("grant", gnt, eg);
        chk("start", spi_start, 1);
        chk("busy_run", busy, 1);
        chk("len", spi_len, el);
        chk("period", spi_period, ep);
        chk("loop", spi_loop, elp);
        chk("odata", spi_odata, eo);
        mptr = (w + 1) % 4;
        scramble();
        spi_idata = id;
        for (int c = 0; c <= stop; c++) begin
            spi_end = (c == lat) || (e0 && c == 0);
            @(negedge clk);
            if (c < stop) begin
                chk("run_done", done, 0);
                chk("run_err", err, 0);
                chk("run_gnt", gnt, eg);
                chk("run_odata", spi_odata, eo);
            end
        end
        spi_end = 1'b0;
        chk("done", done, ok ? eg : 4'd0);
        chk("err", err, ok ? 4'd0 : eg);
        if (ok) mrdata = id;
        chk("rdata", rdata, mrdata);
        chk("end_gnt", gnt, 0);
        chk("end_start", spi_start, 0);
        chk("gap_busy", busy, 1);
    endtask

    task automatic gap(input logic [3:0] nreq);
        req = nreq;
        @(negedge clk);
        chk("pulse_done", done, 0);
        chk("pulse_err", err, 0);
        chk("gap_start", spi_start, 0);
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);
    endtask

    initial begin
        scramble();
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", spi_start, 0);
        chk("rst_loop", spi_loop, 0);
        chk("rst_len", spi_len, 0);
        chk("rst_period", spi_period, 0);
        chk("rst_odata", spi_odata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("noreq_gnt", gnt, 0);
        chk("noreq_busy", busy, 0);
        chk("noreq_start", spi_start, 0);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            txn($urandom_range(1, 6), 1'b0);
            gap(t == 4 ? 4'b0000 : 4'b1111);
        end
        req_len[7:4] = 4'h7;
        req_period[7:4] = 4'h1;
        req_odata[63:32] = 32'hA500_0000;
        req_loop[1] = 1'b1;
        req = 4'b0010;
        txn(3, 1'b0);
        gap(4'b0000);
        req = 4'b0001;
        txn(1, 1'b1);
        gap(4'b0000);
        req = 4'b0010;
        txn(TO, 1'b0);
        gap(4'b0000);
        req = 4'b0100;
        txn(TO + 5, 1'b0);
        gap(4'b0000);
        req = 4'($urandom_range(1, 15));
        for (int t = 0; t < 8; t++) begin
            txn($urandom_range(1, TO + 4), 1'($urandom_range(0, 1)));
            gap(t == 7 ? 4'b0000 : 4'($urandom_range(1, 15)));
        end
        req = 4'b0100;
        @(negedge clk);
        chk("pre_rst_gnt", gnt, 4'b0100);
        chk("pre_rst_start", spi_start, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_start", spi_start, 0);
        chk("async_gnt", gnt, 0);
        chk("async_busy", busy, 0);
        chk("async_rdata", rdata, 0);
        mptr = 0;
        mrdata = '0;
        req = 4'b1000;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", done, 0);
            chk("rst_hold_err", err, 0);
            chk("rst_hold_start", spi_start, 0);
        end
        rst_n = 1'b1;
        txn(2, 1'b0);
        gap(4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
